// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory SRAM adapter.
// Access sizes, response FSM states, per-request context and store byte-mask generation.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_X = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LIVE = 2'd1,
        HELD = 2'd2
    } rsp_state_e;

    typedef struct packed {
        logic [1:0] off;
        size_e      size;
        logic       uns;
        logic       we;
        logic       err;
    } dmem_ctx_t;

    localparam int unsigned LANES = 4;

    function automatic logic [LANES-1:0] wmask_f(input size_e size, input logic [1:0] off);
        case (size)
            SIZE_B:  wmask_f = 4'b0001 << off;
            SIZE_H:  wmask_f = 4'b0011 << off;
            SIZE_W:  wmask_f = 4'hF;
            default: wmask_f = 4'h0;
        endcase
    endfunction

    // Store data is presented right-aligned; every lane gets a copy so the mask alone picks the bytes.
    function automatic logic [31:0] lane_rep_f(input size_e size, input logic [31:0] wdata);
        case (size)
            SIZE_B:  lane_rep_f = {4{wdata[7:0]}};
            SIZE_H:  lane_rep_f = {2{wdata[15:0]}};
            default: lane_rep_f = wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load result formatting: selects the addressed byte/half of an SRAM word
// and sign- or zero-extends it; word loads pass straight through.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{off, 3'b000} +: 8];
    // Halves are always naturally aligned, so only off[1] matters here.
    assign half_sel = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (size)
            SIZE_B:  data = {{24{~uns & byte_sel[7]}}, byte_sel};
            SIZE_H:  data = {{16{~uns & half_sel[15]}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_sram_adapter.sv
// LSU valid/ready request to 1RW SRAM port adapter: byte masks, lane replication,
// access checking and an IDLE/LIVE/HELD response stage with single-entry hold.
module dmem_sram_adapter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [3:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    rsp_state_e  state_reg, state_next;
    dmem_ctx_t   ctx_reg, ctx_next;
    logic [31:0] hold_reg;

    logic [31:0] rel_addr;
    logic [1:0]  off;
    size_e       size;
    logic        in_window;
    logic        req_err;
    logic        fire;
    logic        store_en;
    logic [31:0] load_data;

    // BASE_ADDR is window-aligned, so the low bits of rel_addr equal the byte offset and
    // any address below the base wraps to a large value and fails the window test.
    assign rel_addr  = req_addr - BASE_ADDR;
    assign off       = rel_addr[1:0];
    assign size      = size_e'(req_size);
    assign in_window = (rel_addr[31:ADDR_WIDTH+2] == '0);

    assign req_err = (size == SIZE_X)
                  || ((size == SIZE_H) && off[0])
                  || ((size == SIZE_W) && (off != 2'b00))
                  || !in_window;

    assign req_ready = rst_n && ((state_reg == IDLE) || rsp_ready);
    assign fire      = req_valid && req_ready;
    assign store_en  = rst_n && req_we;

    assign sram_csb0   = !(fire && !req_err);
    assign sram_web0   = !store_en;
    assign sram_wmask0 = store_en ? wmask_f(size, off) : 4'h0;
    assign sram_addr0  = rel_addr[ADDR_WIDTH+1:2];
    assign sram_din0   = lane_rep_f(size, req_wdata);

    dmem_load_align u_align (
        .word (sram_dout0),
        .off  (ctx_reg.off),
        .size (ctx_reg.size),
        .uns  (ctx_reg.uns),
        .data (load_data)
    );

    always_comb begin
        state_next = state_reg;
        ctx_next   = ctx_reg;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;

        case (state_reg)
            LIVE: begin
                rsp_valid  = 1'b1;
                rsp_err    = ctx_reg.err;
                rsp_rdata  = (ctx_reg.we || ctx_reg.err) ? 32'h0 : load_data;
                state_next = rsp_ready ? IDLE : HELD;
            end
            HELD: begin
                rsp_valid = 1'b1;
                rsp_err   = ctx_reg.err;
                rsp_rdata = hold_reg;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new request always wins; the SRAM output it reads replaces the old word.
        if (fire) begin
            state_next    = LIVE;
            ctx_next.off  = off;
            ctx_next.size = size;
            ctx_next.uns  = req_unsigned;
            ctx_next.we   = req_we;
            ctx_next.err  = req_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ctx_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ctx_reg   <= ctx_next;
            if ((state_reg == LIVE) && !rsp_ready) begin
                hold_reg <= rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_sram_adapter.sv
// Directed bench for dmem_sram_adapter with a behavioural 1RW SRAM
// (inputs registered at posedge, access performed at the following negedge).
module tb_dmem_sram_adapter;

    localparam int unsigned AW   = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          sram_csb0;
    logic          sram_web0;
    logic [3:0]    sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [31:0]   sram_din0;
    logic [31:0]   sram_dout0;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_sram_adapter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .sram_csb0    (sram_csb0),
        .sram_web0    (sram_web0),
        .sram_wmask0  (sram_wmask0),
        .sram_addr0   (sram_addr0),
        .sram_din0    (sram_din0),
        .sram_dout0   (sram_dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM macro
    logic [31:0]   mem [0:255];
    logic          m_csb;
    logic          m_web;
    logic [3:0]    m_mask;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_din;

    initial begin
        for (int w = 0; w < 256; w++) mem[w] = 32'hBAD0_0000 | w;
    end

    always @(posedge clk) begin
        m_csb  <= sram_csb0;
        m_web  <= sram_web0;
        m_mask <= sram_wmask0;
        m_addr <= sram_addr0;
        m_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (m_csb == 1'b0) begin
            if (m_web == 1'b0) begin
                for (int l = 0; l < 4; l++)
                    if (m_mask[l]) mem[m_addr][8*l +: 8] <= m_din[8*l +: 8];
            end else begin
                sram_dout0 <= mem[m_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request with rsp_ready held high; starts and ends 1 time unit after a posedge.
    task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] exp_wmask, input logic [AW-1:0] exp_addr,
                        input logic [31:0] exp_din, input logic [31:0] exp_rdata, input logic exp_err);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        rsp_ready    = 1'b1;
        #7;
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_csb"}, sram_csb0, exp_err);
        check({tag, "_early"}, rsp_valid, 0);
        check({tag, "_wmask"}, sram_wmask0, exp_wmask);
        if (!exp_err) check({tag, "_addr"}, sram_addr0, exp_addr);
        if (we && !exp_err) check({tag, "_din"}, sram_din0, exp_din);
        tick();
        req_valid = 1'b0;
        #7;
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, rsp_err, exp_err);
        $display("xact %s we=%0d size=%0d addr=%h rdata=%h err=%0b", tag, we, size, addr, rsp_rdata, rsp_err);
        tick();
    endtask

    initial begin
        logic [31:0] b2b_exp;

        rst_n        = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = BASE;
        req_wdata    = 32'hFFFF_FFFF;
        rsp_ready    = 1'b1;
        #3;
        check("rst_ready", req_ready, 0);
        check("rst_csb", sram_csb0, 1);
        check("rst_web", sram_web0, 1);
        check("rst_wmask", sram_wmask0, 4'h0);
        check("rst_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", rsp_err, 0);
        tick();
        tick();
        rst_n     = 1'b1;
        req_valid = 1'b0;
        tick();

        // Byte store / load and sign handling
        xact("st_b13",  1, 2'd0, 0, BASE + 32'h13, 32'h0000_00A5, 4'b1000, 8'h04, 32'hA5A5_A5A5, 32'h0, 0);
        xact("ld_bu13", 0, 2'd0, 1, BASE + 32'h13, 32'h0,         4'b0000, 8'h04, 32'h0, 32'h0000_00A5, 0);
        xact("st_w20",  1, 2'd2, 0, BASE + 32'h20, 32'h8000_7F80, 4'hF,    8'h08, 32'h8000_7F80, 32'h0, 0);
        xact("ld_bs20", 0, 2'd0, 0, BASE + 32'h20, 32'h0,         4'h0,    8'h08, 32'h0, 32'hFFFF_FF80, 0);
        xact("ld_bs21", 0, 2'd0, 0, BASE + 32'h21, 32'h0,         4'h0,    8'h08, 32'h0, 32'h0000_007F, 0);
        xact("ld_hu22", 0, 2'd1, 1, BASE + 32'h22, 32'h0,         4'h0,    8'h08, 32'h0, 32'h0000_8000, 0);
        xact("ld_hs20", 0, 2'd1, 0, BASE + 32'h20, 32'h0,         4'h0,    8'h08, 32'h0, 32'h0000_7F80, 0);
        xact("st_h22",  1, 2'd1, 0, BASE + 32'h22, 32'h0000_1234, 4'b1100, 8'h08, 32'h1234_1234, 32'h0, 0);
        xact("ld_w20",  0, 2'd2, 0, BASE + 32'h20, 32'h0,         4'h0,    8'h08, 32'h0, 32'h1234_7F80, 0);

        // Error cases: no SRAM access, error flag, zero data
        xact("err_h03",  0, 2'd1, 0, BASE + 32'h03,  32'h0, 4'h0, 8'h00, 32'h0, 32'h0, 1);
        xact("err_sz3",  0, 2'd3, 0, BASE,           32'h0, 4'h0, 8'h00, 32'h0, 32'h0, 1);
        xact("err_w22",  0, 2'd2, 0, BASE + 32'h22,  32'h0, 4'h0, 8'h00, 32'h0, 32'h0, 1);
        xact("err_hi",   0, 2'd2, 0, BASE + 32'h400, 32'h0, 4'h0, 8'h00, 32'h0, 32'h0, 1);
        xact("err_lo",   0, 2'd2, 0, BASE - 32'h4,   32'h0, 4'h0, 8'h00, 32'h0, 32'h0, 1);

        // Back-pressure with a blocked store behind the held load
        xact("st_w40", 1, 2'd2, 0, BASE + 32'h40, 32'h1122_3344, 4'hF, 8'h10, 32'h1122_3344, 32'h0, 0);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = BASE + 32'h40; rsp_ready = 1'b0;
        #7;
        check("bp_ld_csb", sram_csb0, 0);
        tick();
        req_we = 1'b1; req_addr = BASE + 32'h44; req_wdata = 32'h5566_7788;
        for (int c = 0; c < 3; c++) begin
            #7;
            check("bp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, 32'h1122_3344);
            check("bp_ready", req_ready, 0);
            check("bp_csb", sram_csb0, 1);
            $display("xact bp_hold cycle=%0d rdata=%h ready=%0b", c, rsp_rdata, req_ready);
            tick();
        end
        rsp_ready = 1'b1;
        #7;
        check("bp_rel_ready", req_ready, 1);
        check("bp_rel_rdata", rsp_rdata, 32'h1122_3344);
        check("bp_rel_csb", sram_csb0, 0);
        tick();
        req_valid = 1'b0;
        #7;
        check("bp_st_valid", rsp_valid, 1);
        check("bp_st_rdata", rsp_rdata, 32'h0);
        tick();
        xact("ld_w44", 0, 2'd2, 0, BASE + 32'h44, 32'h0, 4'h0, 8'h11, 32'h0, 32'h5566_7788, 0);

        // Back-to-back alternating word store / load, one request per cycle
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                req_valid = 1'b1;
                req_we    = (k % 2 == 0);
                req_size  = 2'd2;
                req_addr  = BASE + 32'h80 + 32'(4 * (k / 2));
                req_wdata = 32'hC0DE_0000 + 32'(k / 2) * 32'h0001_0101;
            end else begin
                req_valid = 1'b0;
            end
            #7;
            if (k < 16) check("b2b_ready", req_ready, 1);
            if (k > 0) begin
                b2b_exp = ((k - 1) % 2 == 0) ? 32'h0 : 32'hC0DE_0000 + 32'((k - 1) / 2) * 32'h0001_0101;
                check("b2b_valid", rsp_valid, 1);
                check("b2b_rdata", rsp_rdata, b2b_exp);
                $display("xact b2b rsp=%0d rdata=%h", k - 1, rsp_rdata);
            end
            tick();
        end

        // Reset in the LIVE cycle drops the response
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = BASE + 32'h40; rsp_ready = 1'b1;
        #7;
        tick();
        check("rl_live", rsp_valid, 1);
        rst_n  = 1'b0;
        req_we = 1'b1;
        #1;
        check("rl_valid", rsp_valid, 0);
        check("rl_csb", sram_csb0, 1);
        check("rl_web", sram_web0, 1);
        check("rl_wmask", sram_wmask0, 4'h0);
        check("rl_ready", req_ready, 0);
        tick();
        tick();
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #7;
        check("rl_idle", rsp_valid, 0);
        $display("xact reset_live rsp_valid=%0b", rsp_valid);
        tick();
        xact("rl_ld_w40", 0, 2'd2, 0, BASE + 32'h40, 32'h0, 4'h0, 8'h10, 32'h0, 32'h1122_3344, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
